// File: rtl/ternary_mul_seq.sv
// ---------------------------------------------------------------------------
// ternary_mul_seq -- multi-cycle balanced-ternary multiplier controller.
//
// Forms a * b by Horner's rule, most-significant multiplier trit first:
// every iteration shifts the accumulator up one trit and then adds or
// subtracts the multiplicand according to the current multiplier trit.
// All arithmetic goes through one ternary_alu instance. The file also holds
// ternary_pkg (trit encoding, ALU opcodes) and ternary_alu.
//
// Ports (ternary_mul_seq):
//   clk      in  rising-edge clock
//   rst_n    in  asynchronous active-low reset
//   start    in  request, sampled only while ready = 1
//   a, b     in  multiplicand / multiplier, WIDTH trits, latched on accept
//   ready    out high while idle
//   done     out one-cycle pulse, product/overflow valid from this cycle on
//   product  out low WIDTH trits of the exact product
//   overflow out exact product does not fit in WIDTH trits
//
// Configuration macro: TMUL_SKIP_ZERO_EN
//   defined   -> zero multiplier trits skip the accumulate step
//                (latency 1 + WIDTH + nonzero trits of b)
//   undefined -> accumulate step for every trit (latency 1 + 2*WIDTH)
// ---------------------------------------------------------------------------

package ternary_pkg;
    typedef logic [1:0] trit_t;

    localparam trit_t T_ZERO    = 2'b00;
    localparam trit_t T_POS_ONE = 2'b01;
    localparam trit_t T_NEG_ONE = 2'b10;

    typedef enum logic [1:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SHL
    } alu_op_t;

    // The unused encoding 2'b11 reads as zero everywhere.
    function automatic int trit_val(input trit_t t);
        case (t)
            T_POS_ONE: return 1;
            T_NEG_ONE: return -1;
            default:   return 0;
        endcase
    endfunction

    function automatic trit_t trit_enc(input int v);
        if (v > 0)
            return T_POS_ONE;
        else if (v < 0)
            return T_NEG_ONE;
        else
            return T_ZERO;
    endfunction
endpackage

// ---------------------------------------------------------------------------
// ternary_alu -- combinational balanced-ternary ALU.
//   a, b       operands (WIDTH trits)
//   op         ALU_ADD / ALU_SUB (a - b) / ALU_SHL (a shifted up one trit)
//   result     WIDTH-trit result
//   carry      trit carried out of the top (for SHL: the trit shifted out)
//   zero_flag  result is all zero
//   neg_flag   result is negative (most significant nonzero trit is -1)
// ---------------------------------------------------------------------------
module ternary_alu
    import ternary_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  trit_t [WIDTH-1:0] a,
    input  trit_t [WIDTH-1:0] b,
    input  alu_op_t           op,
    output trit_t [WIDTH-1:0] result,
    output trit_t             carry,
    output logic              zero_flag,
    output logic              neg_flag
);

    // Ripple add/subtract: each digit sum lies in -3..+3 and is folded back
    // into -1..+1 with a carry of -1, 0 or +1 into the next trit.
    always_comb begin
        int c;
        int s;
        result = '0;
        carry  = T_ZERO;
        c      = 0;
        s      = 0;
        if (op == ALU_SHL) begin
            result = {a[WIDTH-2:0], T_ZERO};
            carry  = trit_enc(trit_val(a[WIDTH-1]));
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                s = trit_val(a[i]) + c +
                    ((op == ALU_SUB) ? -trit_val(b[i]) : trit_val(b[i]));
                if (s > 1) begin
                    result[i] = trit_enc(s - 3);
                    c         = 1;
                end else if (s < -1) begin
                    result[i] = trit_enc(s + 3);
                    c         = -1;
                end else begin
                    result[i] = trit_enc(s);
                    c         = 0;
                end
            end
            carry = trit_enc(c);
        end
    end

    // Sign comes from the most significant nonzero trit, so scan upwards and
    // let the last nonzero trit win.
    always_comb begin
        zero_flag = 1'b1;
        neg_flag  = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (trit_val(result[i]) != 0) begin
                zero_flag = 1'b0;
                neg_flag  = (result[i] == T_NEG_ONE);
            end
        end
    end

endmodule

module ternary_mul_seq
    import ternary_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  trit_t [WIDTH-1:0] a,
    input  trit_t [WIDTH-1:0] b,
    output logic              ready,
    output logic              done,
    output trit_t [WIDTH-1:0] product,
    output logic              overflow
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    trit_t [WIDTH-1:0] a_r;
    trit_t [WIDTH-1:0] b_r;
    trit_t [WIDTH-1:0] acc;
    logic [IDX_W-1:0]  idx;
    logic              ovf;

    alu_op_t           alu_op;
    trit_t [WIDTH-1:0] alu_b;
    trit_t [WIDTH-1:0] alu_result;
    trit_t             alu_carry;
    logic              alu_zero_unused;
    logic              alu_neg_unused;

    logic              trit_pos;
    logic              trit_neg;
    logic              ovf_next;

    assign trit_pos = (b_r[idx] == T_POS_ONE);
    assign trit_neg = (b_r[idx] == T_NEG_ONE);

    ternary_alu #(.WIDTH(WIDTH)) u_alu (
        .a         (acc),
        .b         (alu_b),
        .op        (alu_op),
        .result    (alu_result),
        .carry     (alu_carry),
        .zero_flag (alu_zero_unused),
        .neg_flag  (alu_neg_unused)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // Next state, ALU control, handshake outputs and the overflow update
    // contributed by the current step.
    always_comb begin
        next_state = state;
        alu_op     = ALU_ADD;
        alu_b      = a_r;
        ready      = 1'b0;
        done       = 1'b0;
        ovf_next   = ovf;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start)
                    next_state = S_SHIFT;
            end
            S_SHIFT: begin
                alu_op   = ALU_SHL;
                ovf_next = ovf | (trit_val(acc[WIDTH-1]) != 0);
`ifdef TMUL_SKIP_ZERO_EN
                if (trit_pos || trit_neg)
                    next_state = S_ACCUM;
                else if (idx == '0)
                    next_state = S_DONE;
`else
                next_state = S_ACCUM;
`endif
            end
            S_ACCUM: begin
                alu_op = trit_neg ? ALU_SUB : ALU_ADD;
`ifndef TMUL_SKIP_ZERO_EN
                // A zero trit still takes this step, adding nothing.
                if (!(trit_pos || trit_neg))
                    alu_b = '0;
`endif
                ovf_next = ovf | (alu_carry != T_ZERO);
                if (idx == '0)
                    next_state = S_DONE;
                else
                    next_state = S_SHIFT;
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Datapath. The result registers are loaded on the edge that enters
    // DONE so that product/overflow are already valid while done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            b_r      <= '0;
            acc      <= '0;
            idx      <= '0;
            ovf      <= 1'b0;
            product  <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_r <= a;
                        b_r <= b;
                        acc <= '0;
                        idx <= IDX_W'(WIDTH - 1);
                        ovf <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    acc <= alu_result;
                    ovf <= ovf_next;
`ifdef TMUL_SKIP_ZERO_EN
                    if (!(trit_pos || trit_neg) && idx != '0)
                        idx <= idx - 1'b1;
`endif
                end
                S_ACCUM: begin
                    acc <= alu_result;
                    ovf <= ovf_next;
                    if (idx != '0)
                        idx <= idx - 1'b1;
                end
                default: ;
            endcase
            if (next_state == S_DONE && state != S_DONE) begin
                product  <= alu_result;
                overflow <= ovf_next;
            end
        end
    end

endmodule
